ic_2519: RTL and testbench

- Behavioural model of the Signetics 2519 hex 40-bit static shift register, used as the character line buffer.
- Six parallel 40-stage serial shift registers, clocked in step, with a recirculate path.
- Output word feeds the downstream ic_7404 hex inverter bit-for-bit (dout[5:0] -> a[5:0]).
- Real-chip clock gating is modelled as a synchronous shift enable on the single system clock.

---
 rtl/ic_2519.sv | 67 ++++++
 tb/tb_ic_2519.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ic_2519.sv
// ic_2519 - behavioural model of the Signetics 2519 hex 40-bit static shift
// register, used as the character line buffer. Six independent bit lanes
// shift in step on a synchronous enable. A recirculate path feeds the oldest
// word back into stage 0. The output word drives the ic_7404 hex inverter.
`timescale 1ns/1ps
module ic_2519 #(
  parameter int                 DEPTH      = 40,   // stages per lane, 2..64
  parameter int                 WIDTH      = 6,    // parallel bit lanes
  parameter logic [WIDTH-1:0]   RESET_WORD = '0    // every stage after reset
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             recirc,
  input  logic [WIDTH-1:0] din,
  input  logic             oe,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] tap0
);

  // The storage is a true shift chain: stage[0] is the newest word and
  // stage[DEPTH-1] is the oldest. Each lane is one bit column of this array,
  // so lanes never mix.
  logic [WIDTH-1:0] stage [DEPTH];
  logic [WIDTH-1:0] feed;

  // Select the word that enters stage 0. When recirc=1 the oldest word goes
  // back in, so an X on din cannot reach the storage in that mode.
  always_comb begin
    feed = din;
    if (recirc) begin
      feed = stage[DEPTH-1];
    end
  end

  // Shift chain with asynchronous clear of every stage.
  // NOTE: the storage is cleared in full on reset. The line buffer has to
  // come up in a known state, and a partially cleared chain would later push
  // X onto dout. Non-blocking assignments let every stage take its
  // neighbour's pre-edge value, which keeps the shift order independent of
  // the loop order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_WORD;
      end
    end else if (shift_en) begin
      stage[0] <= feed;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // The output path has no register, so an oe change shows on dout in the
  // same cycle. When oe is off, dout is forced to all ones.
  always_comb begin
    dout = '1;
    if (oe) begin
      dout = stage[DEPTH-1];
    end
  end

  // Debug tap on the newest stage. It is not gated by oe.
  assign tap0 = stage[0];

endmodule

// File: tb/tb_ic_2519.sv
// Directed testbench for ic_2519 at the default DEPTH=40, WIDTH=6.
`timescale 1ns/1ps
module tb_ic_2519;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift_en;
  logic       recirc;
  logic [5:0] din;
  logic       oe;
  logic [5:0] dout;
  logic [5:0] tap0;

  int checks = 0;
  int errors = 0;

  ic_2519 dut (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .recirc   (recirc),
    .din      (din),
    .oe       (oe),
    .dout     (dout),
    .tap0     (tap0)
  );

  always #5 clk = ~clk;

  // Count one comparison. A 4-state compare means X or Z never passes.
  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One enabled shift. Inputs are driven at the falling edge, and outputs
  // settle 1 ns after the rising edge.
  task automatic shift(input logic rc, input logic [5:0] d);
    @(negedge clk);
    shift_en = 1'b1;
    recirc   = rc;
    din      = d;
    @(posedge clk);
    #1;
    shift_en = 1'b0;
  endtask

  // One clock with shift_en low. recirc and din carry junk that must be ignored.
  task automatic idle(input logic rc, input logic [5:0] d);
    @(negedge clk);
    shift_en = 1'b0;
    recirc   = rc;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] held_dout;
  logic [5:0] held_tap;

  initial begin
    rst = 1'b1; shift_en = 1'b0; recirc = 1'b0; din = 6'h00; oe = 1'b1;
    #3;
    check("reset_dout", dout, 6'h00);
    check("reset_tap0", tap0, 6'h00);
    oe = 1'b0;
    #1;
    check("oe_off_dout", dout, 6'h3F);
    oe = 1'b1;
    #1;
    check("oe_on_dout", dout, 6'h00);
    @(negedge clk);
    rst = 1'b0;

    // Load the words 0..39. Word 0 reaches dout on the 40th edge.
    for (int k = 0; k < 40; k++) shift(1'b0, 6'(k));
    check("load_dout", dout, 6'h00);
    check("load_tap0", tap0, 6'd39);

    // Recirculate 39 edges. dout steps through 1..39, and tap0 holds the word
    // that was just fed back.
    for (int j = 1; j < 40; j++) begin
      shift(1'b1, 6'h00);
      check("recirc_dout", dout, 6'(j));
      check("recirc_tap0", tap0, 6'(j-1));
    end
    shift(1'b1, 6'h00);   // completes a full rotation
    check("rot_dout", dout, 6'h00);

    // Three more full rotations. din is X to show that nothing leaks into
    // the storage while recirculating.
    for (int n = 0; n < 120; n++) begin
      shift(1'b1, 6'bx);
      check("rot3_dout", dout, 6'((n + 1) % 40));
      check("rot3_tap0", tap0, 6'(n % 40));
    end

    // Load the pattern 2A+k, then freeze mid-stream for 10 cycles.
    for (int k = 0; k < 40; k++) shift(1'b0, 6'h2A + 6'(k));
    check("pat_dout", dout, 6'h2A);
    for (int k = 1; k <= 5; k++) begin
      shift(1'b1, 6'h00);
      check("pat_pre", dout, 6'h2A + 6'(k));
    end
    held_dout = 6'h2A + 6'd5;
    held_tap  = 6'h2A + 6'd4;
    for (int c = 0; c < 10; c++) begin
      idle(c[0], 6'(c * 7));
      check("freeze_dout", dout, held_dout);
      check("freeze_tap0", tap0, held_tap);
    end
    for (int k = 6; k <= 10; k++) begin
      shift(1'b1, 6'h00);
      check("pat_resume", dout, 6'h2A + 6'(k));
    end

    // Fill the register with 15, then reset asynchronously between edges.
    for (int k = 0; k < 40; k++) shift(1'b0, 6'h15);
    check("fill15_dout", dout, 6'h15);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dout", dout, 6'h00);
    check("async_rst_tap0", tap0, 6'h00);
    shift(1'b0, 6'h3F);   // the clock edge must be ignored while rst=1
    check("rst_hold_tap0", tap0, 6'h00);
    @(negedge clk);
    rst = 1'b0;
    shift(1'b0, 6'h3F);
    check("post_rst_tap0", tap0, 6'h3F);
    check("post_rst_dout", dout, 6'h00);

    // Drive the downstream ic_7404 inverter with 40 words of 01. It must
    // output 3E on every recirculated cycle.
    for (int k = 0; k < 40; k++) shift(1'b0, 6'h01);
    for (int k = 0; k < 40; k++) begin
      shift(1'b1, 6'h00);
      check("inv_y", ~dout, 6'h3E);
    end
    oe = 1'b0;
    #1;
    check("inv_oe_off", ~dout, 6'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
